// File: rtl/csa_accum_seq_if.sv
// Operand/result stream bundle for csa_accum_seq: job control, operand beats, results
// and a debug view of the sequencer state.
interface csa_accum_seq_if #(
  parameter int MAX   = 7,
  parameter int INPUT = 7
);
  // Handshake rule for both streams: a transfer happens on a rising clk edge where
  // valid && ready are both high; the producer holds valid and payload stable until then,
  // and ready is a decode of registered state only, never a function of valid.
  logic                         start;
  logic [7:0]                   n_ops;
  logic                         clr;
  logic                         idle;
  logic                         op_valid;
  logic [MAX*(INPUT-2)-1:0]     op_data;
  logic                         op_ready;
  logic                         res_valid;
  logic [MAX-1:0]               res_data;
  logic                         res_ready;
  logic [1:0]                   fsm_state;

  modport master (
    output start, n_ops, clr, op_valid, op_data, res_ready,
    input  idle, op_ready, res_valid, res_data, fsm_state
  );

  modport slave (
    input  start, n_ops, clr, op_valid, op_data, res_ready,
    output idle, op_ready, res_valid, res_data, fsm_state
  );
endinterface

// File: rtl/csa_accum_seq.sv
// Sequencer that folds a job of n_ops operands, LANES per beat, into a carry-save running
// sum held in s/c, then resolves it with one carry-propagate add.
module csa_accum_seq #(
  parameter int MAX   = 7,
  parameter int INPUT = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  csa_accum_seq_if.slave bus
);
  localparam int LANES = INPUT - 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t         state;
  logic [7:0]     remaining;
  logic [MAX-1:0] s;
  logic [MAX-1:0] c;
  logic [MAX-1:0] tree_s;
  logic [MAX-1:0] tree_c;
  logic [MAX-1:0] lane;
  logic [MAX-1:0] maj;

  assign bus.idle      = (state == IDLE);
  assign bus.op_ready  = (state == ACCUM);
  assign bus.res_valid = (state == DONE);
  assign bus.fsm_state = state;

  // Carry-save tree: each lane is folded into (tree_s, tree_c) by a 3:2 compressor row,
  // so tree_s + tree_c always equals s + c + masked lanes mod 2^MAX.
  always_comb begin
    tree_s = s;
    tree_c = c;
    lane   = '0;
    maj    = '0;
    for (int k = 0; k < LANES; k++) begin
      lane   = (8'(k) < remaining) ? bus.op_data[MAX*k +: MAX] : '0;
      maj    = (tree_s & tree_c) | (tree_s & lane) | (tree_c & lane);
      tree_s = tree_s ^ tree_c ^ lane;
      tree_c = maj << 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      remaining    <= '0;
      s            <= '0;
      c            <= '0;
      bus.res_data <= '0;
    end else if (bus.clr) begin
      state        <= IDLE;
      remaining    <= '0;
      s            <= '0;
      c            <= '0;
      bus.res_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            remaining <= bus.n_ops;
            s         <= '0;
            c         <= '0;
            state     <= (bus.n_ops != 8'd0) ? ACCUM : RESOLVE;
          end
        end
        ACCUM: begin
          if (bus.op_valid) begin
            s <= tree_s;
            c <= tree_c;
            if (remaining <= 8'(LANES)) begin
              remaining <= '0;
              state     <= RESOLVE;
            end else begin
              remaining <= remaining - 8'(LANES);
            end
          end
        end
        RESOLVE: begin
          bus.res_data <= s + c;
          state        <= DONE;
        end
        DONE: begin
          if (bus.res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_accum_seq.sv
// Scoreboard bench for csa_accum_seq: directed jobs plus randomized jobs, results checked
// against plain modular sums of the issued operands.
module tb_csa_accum_seq;
  localparam int MAX   = 7;
  localparam int INPUT = 7;
  localparam int LANES = INPUT - 2;
  localparam int W     = MAX;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;
  logic [W-1:0] exp_q[$];
  int   job_ops[$];
  bit   rand_ready;
  bit   ready_force;
  int   pat_i;
  bit   pat [6];

  csa_accum_seq_if #(.MAX(MAX), .INPUT(INPUT)) bus ();

  csa_accum_seq #(.MAX(MAX), .INPUT(INPUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // result-side ready policy
  initial begin
    bus.res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.res_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // monitor: pops the scoreboard on every result handshake, checks hold while stalled
  initial begin : monitor
    bit pending;
    logic [W-1:0] held;
    pending = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          chk("hold_valid", 32'(bus.res_valid), 32'd1);
          chk("hold_data", 32'(bus.res_data), 32'(held));
        end
        if (bus.res_valid && bus.res_ready) begin
          if (exp_q.size() == 0) fail_now("unexpected_result");
          else chk("result", 32'(bus.res_data), 32'(exp_q.pop_front()));
          pending = 1'b0;
        end else if (bus.res_valid) begin
          pending = 1'b1;
          held    = bus.res_data;
        end else begin
          pending = 1'b0;
        end
      end
    end
  end

  // driver tasks
  task automatic send_beat(input logic [MAX*LANES-1:0] data, input int mode);
    bit done;
    bit v;
    bit hs;
    int guard;
    done  = 1'b0;
    guard = 0;
    while (!done) begin
      bus.op_data = data;
      case (mode)
        1:       v = 1'($urandom_range(0, 1));
        2:       begin v = pat[pat_i % 6]; pat_i++; end
        default: v = 1'b1;
      endcase
      bus.op_valid = v;
      hs = v && bus.op_ready;
      tick();
      bus.op_valid = 1'b0;
      if (hs) done = 1'b1;
      else if (++guard > 200) begin
        fail_now("beat_timeout");
        done = 1'b1;
      end
    end
  endtask

  // Issues start, extends job_ops with random operands if short, pushes the modular sum,
  // then sends up to max_beats beats; lanes past n_ops carry fill (or random if fill < 0).
  task automatic run_job(input int n, input int mode, input bit push, input int fill,
                         input int max_beats);
    int sum;
    int nb;
    int idx;
    logic [MAX*LANES-1:0] data;
    bus.start = 1'b1;
    bus.n_ops = 8'(n);
    tick();
    bus.start = 1'b0;
    while (job_ops.size() < n) job_ops.push_back(int'($urandom_range(0, 127)));
    sum = 0;
    for (int i = 0; i < n; i++) sum += job_ops[i];
    if (push) exp_q.push_back(W'(sum % 128));
    nb    = (n + LANES - 1) / LANES;
    pat_i = 0;
    for (int b = 0; b < nb && b < max_beats; b++) begin
      for (int k = 0; k < LANES; k++) begin
        idx = b * LANES + k;
        if (idx < n) data[MAX*k +: MAX] = MAX'(job_ops[idx]);
        else data[MAX*k +: MAX] = (fill >= 0) ? MAX'(fill) : MAX'($urandom_range(0, 127));
      end
      send_beat(data, mode);
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!(bus.idle && !bus.res_valid)) begin
      tick();
      if (++guard > 300) begin
        fail_now("idle_timeout");
        break;
      end
    end
  endtask

  initial begin
    checks       = 0;
    fails        = 0;
    rand_ready   = 1'b0;
    ready_force  = 1'b1;
    pat          = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    pat_i        = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.n_ops    = '0;
    bus.clr      = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_data  = '0;
    #2;
    chk("rst_idle", 32'(bus.idle), 32'd1);
    chk("rst_op_ready", 32'(bus.op_ready), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data", 32'(bus.res_data), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // single beat, latency from beat edge
    job_ops = {1, 2, 3, 4, 5};
    run_job(5, 0, 1'b1, -1, 99);
    chk("t1_resolve_valid", 32'(bus.res_valid), 32'd0);
    chk("t1_resolve_ready", 32'(bus.op_ready), 32'd0);
    tick();
    chk("t1_done_valid", 32'(bus.res_valid), 32'd1);
    wait_idle();

    // partial-lane masking and wrap
    job_ops = {10, 20, 30, 40, 50, 1, 2};
    run_job(7, 0, 1'b1, 99, 99);
    wait_idle();

    // backpressure on both sides, start ignored in DONE
    job_ops.delete();
    for (int i = 0; i < 12; i++) job_ops.push_back(127);
    ready_force = 1'b0;
    run_job(12, 2, 1'b1, -1, 99);
    tick();
    bus.start = 1'b1;
    bus.n_ops = 8'd3;
    repeat (3) tick();
    bus.start   = 1'b0;
    ready_force = 1'b1;
    wait_idle();
    tick();
    tick();
    chk("t3_start_ignored_idle", 32'(bus.idle), 32'd1);
    chk("t3_start_ignored_ready", 32'(bus.op_ready), 32'd0);

    // empty job
    job_ops.delete();
    run_job(0, 0, 1'b1, -1, 99);
    chk("t4_op_ready", 32'(bus.op_ready), 32'd0);
    chk("t4_early_valid", 32'(bus.res_valid), 32'd0);
    tick();
    chk("t4_valid", 32'(bus.res_valid), 32'd1);
    chk("t4_op_ready_done", 32'(bus.op_ready), 32'd0);
    wait_idle();

    // abort after first beat
    job_ops.delete();
    run_job(10, 0, 1'b0, -1, 1);
    bus.clr      = 1'b1;
    bus.op_valid = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("t5_idle", 32'(bus.idle), 32'd1);
    chk("t5_op_ready", 32'(bus.op_ready), 32'd0);
    chk("t5_res_data_clr", 32'(bus.res_data), 32'd0);
    tick();
    bus.op_valid = 1'b0;
    chk("t5_still_idle", 32'(bus.idle), 32'd1);
    job_ops = {4, 5, 6};
    run_job(3, 0, 1'b1, -1, 99);
    wait_idle();

    // reset during RESOLVE, previous result 15 still in res_data
    job_ops = {1, 2, 3, 4, 5};
    run_job(5, 0, 1'b0, -1, 99);
    rst_n = 1'b0;
    #1;
    chk("t6_res_valid", 32'(bus.res_valid), 32'd0);
    chk("t6_res_data", 32'(bus.res_data), 32'd0);
    chk("t6_idle", 32'(bus.idle), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    job_ops = {1, 1, 1, 1, 1};
    run_job(5, 0, 1'b1, -1, 99);
    wait_idle();

    // randomized jobs with random stalls on both streams
    rand_ready = 1'b1;
    for (int j = 0; j < 25; j++) begin
      job_ops.delete();
      run_job(int'($urandom_range(0, 40)), 1, 1'b1, -1, 99);
      wait_idle();
    end
    rand_ready = 1'b0;
    tick();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/csa_accum_seq.md
# csa_accum_seq

Multi-cycle sequencer that feeds a job of N operands, LANES per beat, into one shared `CSA_auto` carry-save tree. The running sum is held in carry-save form (sum/carry registers) and recirculated through the tree. A single carry-propagate add at the end resolves the total. It sits between an operand producer (valid/ready stream) and a result consumer (valid/ready), so that a fixed-size tree can handle arbitrarily long popcount or multi-operand sums.

## Interface
- `MAX`, default 7: operand, accumulator and result width in bits.
- `INPUT`, default 7: tree inputs per cycle, legal 3..7. `LANES = INPUT-2` new operands per beat; the other two inputs are the sum and carry registers.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a job; accepted only in IDLE.
- `n_ops`  in  8  operand count for the job, 0..255, sampled with an accepted `start`.
- `clr`  in  1  synchronous abort, any state.
- `idle`  out  1  high in IDLE.
- `op_valid`  in  1  operand beat valid.
- `op_data`  in  MAX*LANES  lane k at bits `[MAX*k +: MAX]`.
- `op_ready`  out  1  beat accept.
- `res_valid`  out  1  result valid.
- `res_data`  out  MAX  job total mod 2^MAX.
- `res_ready`  in  1  result accept.

## Operation
- **FSM states:** IDLE, ACCUM, RESOLVE, DONE.
- **IDLE:**
  - On `start`: latch `remaining = n_ops` and clear `s` and `c` to 0.
  - Go to ACCUM if `n_ops != 0`, else go to RESOLVE.
- **ACCUM:**
  - `op_ready = 1`.
  - On a handshake (`op_valid & op_ready`):
    - Lane k is presented to the tree only if `k < remaining`; otherwise it is forced to 0.
    - Tree inputs are {masked lanes, `s`, `c`}. Tree `pv_s` and `pv_c` are registered into `s` and `c`.
    - `remaining -= min(LANES, remaining)`.
  - Go to RESOLVE when the handshake makes `remaining` 0.
  - Without a handshake, nothing changes.
- **RESOLVE:** `res_data <= s + c` (MAX-bit, carry-out dropped). Always go to DONE after one cycle.
- **DONE:** `res_valid = 1` and `res_data` is held until `res_ready`. On that handshake go to IDLE.
- **Arithmetic:**
  - All values are unsigned and taken modulo 2^MAX.
  - The sum/carry alignment is whatever `CSA_auto` defines, such that `pv_s + pv_c` equals the sum of its inputs mod 2^MAX. The block adds no shifts.
- **`start` outside IDLE:** ignored; `n_ops` is not resampled.
- **`clr`:**
  - Highest priority.
  - Next state is IDLE; `s`, `c`, `remaining` and `res_data` go to 0.
  - Any beat or result handshake in the same cycle is discarded.
- **`start` and `clr` in the same cycle in IDLE:** `clr` wins and the job does not start.

## Timing
- **Reset (`rst_n` low):** state IDLE, `idle=1`, `op_ready=0`, `res_valid=0`, `res_data=0`, `s=c=0`, `remaining=0`. Outputs take these values immediately (asynchronous).
- `op_ready`, `res_valid` and `idle` decode only the registered state, with no combinational path from `op_valid` or `res_ready`.
- **`start` at edge T0:**
  - ACCUM from T0+1.
  - With B = ceil(n_ops/LANES) beats and no stalls, the last beat is accepted at T0+B.
  - RESOLVE in cycle T0+B+1; `res_valid` is high from T0+B+2.
- **`n_ops = 0`:** RESOLVE at T0+1, `res_valid` from T0+2.
- **Throughput:** one beat per cycle in ACCUM. A result handshake at edge Tr puts the block in IDLE at Tr+1, and a `start` accepted at that edge begins the next job, so at least one IDLE cycle separates jobs.
- **Result hold:** `res_data` is stable from RESOLVE until the DONE handshake, regardless of `op_valid` or `start`.

## Test plan
Values below use MAX=7, INPUT=7, LANES=5.

1. **Single beat:**
   - Stimulus: `start`, `n_ops=5`, one beat of lanes {1,2,3,4,5}.
   - Required: `res_data=15`, `res_valid` exactly 2 cycles after the beat edge.
2. **Partial-lane masking and wrap:**
   - Stimulus: `n_ops=7`, beats {10,20,30,40,50} and {1,2,99,99,99}.
   - Required: `res_data = 153 mod 128 = 25`; the lanes carrying 99 are ignored.
3. **Backpressure:**
   - Stimulus: `n_ops=12` with `op_valid` toggling 1,0,0,1,0,1; all operands 127.
   - Required:
     - `res_data = 1524 mod 128 = 116`.
     - With `res_ready` low for 3 cycles, `res_valid` and `res_data` stay constant.
     - `start` asserted during DONE is ignored.
4. **Empty job:**
   - Stimulus: `start`, `n_ops=0`.
   - Required: `op_ready` never rises; `res_data=0` with `res_valid` at T0+2.
5. **Abort:**
   - Stimulus: `clr` in the cycle after the first beat of an `n_ops=10` job.
   - Required:
     - `idle=1` next cycle and a following beat is not accepted.
     - A new job with `n_ops=3`, operands {4,5,6}, returns 15.
6. **Reset mid-operation:**
   - Stimulus: drop `rst_n` during RESOLVE.
   - Required: `res_valid=0`, `res_data=0`, `idle=1` immediately. After release, a job with `n_ops=5` of all-1 operands returns 5.
